sa_seq_ctrl: RTL and testbench
==============================

Name: sa_seq_ctrl

Overview:
- Sequencer for the 4x4 systolic-array datapath and its eight 256-bit operand SRAM banks (A0-A3, B0-B3).
- After startSys it walks BankAddr through every test case.
- For each case it clears the PE accumulators, strobes the operand feed element by element, and flags the cycle on which the OpCxy results are valid.
- Sits inside TOP between the bank address/enable pins and the PE array control inputs.

Parameters:
- ADDR_WIDTH, 10, width of BankAddr.
- NUM_CASES, 1024, number of cases processed per run; last address is NUM_CASES-1.
- K_LEN, 8, operand elements fed per case (256-bit row / 32-bit element).
- CASE_CYCLES, 17, cycles spent on each case.
  - Must satisfy CASE_CYCLES >= K_LEN+2.
  - Violation is an elaboration-time $error.
- IDX_WIDTH, 3, width of FeedIdx; must hold K_LEN-1.

Ports:
- clk, input, 1, system clock; rising-edge.
- rstSys, input, 1, asynchronous active-high reset.
- startSys, input, 1, level start request.
- BankAddr, output, ADDR_WIDTH, shared address to all eight banks.
- MemEn, output, 1, bank chip-select; read only.
- PeClear, output, 1, clear PE accumulators.
- FeedValid, output, 1, operand element present on feed this cycle.
- FeedIdx, output, IDX_WIDTH, element index within bank word; 0 when FeedValid=0.
- start_check, output, 1, OpCxy valid for case BankAddr this cycle.
- busy, output, 1, state is RUN.
- done, output, 1, all cases finished.

Behaviour:
- Reset: asynchronous; while rstSys=1 all registers are forced.
  - State=IDLE, cyc=0, BankAddr=0.
  - All outputs 0.
  - Reset asserted mid-run aborts immediately; no partial completion.
- Output style: Moore outputs decoded only from the state, cyc and BankAddr registers. No combinational path from startSys to any output.
- States: IDLE, RUN, DONE.
- IDLE:
  - All outputs 0, BankAddr=0.
  - startSys=1 at a clk edge -> RUN with cyc=0, BankAddr=0.
- RUN:
  - busy=1, MemEn=1.
  - cyc increments each cycle, 0..CASE_CYCLES-1.
  - PeClear=1 only at cyc==0.
  - Bank read latency is 1 cycle: the address presented at cyc 0 returns data from cyc 1.
  - FeedValid=1 for cyc in 1..K_LEN, with FeedIdx=cyc-1.
  - start_check=1 only at cyc==CASE_CYCLES-1, while BankAddr still equals the current case.
  - At cyc==CASE_CYCLES-1:
    - If BankAddr==NUM_CASES-1 -> DONE.
    - Else BankAddr<=BankAddr+1 and cyc<=0.
  - BankAddr never wraps inside a run.
  - startSys deassertion during RUN is ignored; the run always completes.
- DONE:
  - done=1, busy=0, MemEn=0, BankAddr holds NUM_CASES-1.
  - startSys=0 -> IDLE (re-arm).
  - While startSys stays 1, remains in DONE; a level-held start never restarts a run.
- Run length: a full run from the first RUN cycle to the DONE entry is NUM_CASES*CASE_CYCLES cycles (17408 at defaults).
- Counter widths: cyc is wide enough for CASE_CYCLES-1. The FeedIdx subtraction never underflows, because it is only decoded when cyc>=1.

Optional Feature:
- Macro: SA_SEQ_CTRL_STALL_EN.
- Defined: adds input port stall (1 bit), sampled in RUN.
  - While stall=1: cyc and BankAddr hold, and PeClear, FeedValid and start_check are forced 0.
  - While stall=1: FeedIdx holds its value and MemEn stays 1.
  - Dropping stall resumes at the held cyc.
  - A stall arriving at cyc==CASE_CYCLES-1 suppresses that start_check until release; no case is skipped or repeated.
  - stall is ignored in IDLE and DONE.
- Undefined: no stall port; behaviour is identical to stall tied 0.

Test Plan:
- Reset then idle: rstSys pulse, startSys=0 for 20 cycles -> all outputs 0, BankAddr=0.
- Single case timing (NUM_CASES=1): startSys=1 ->
  - PeClear at RUN cycle 0.
  - FeedValid cycles 1-8 with FeedIdx 0..7.
  - start_check at cycle 16 with BankAddr=0.
  - done at cycle 17.
- Full default run: startSys held 1 ->
  - Exactly 1024 start_check pulses, 17 cycles apart, BankAddr 0..1023 in order.
  - done after 17408 cycles; stays in DONE while startSys=1.
- Re-arm: after done, startSys 0 for 1 cycle then 1 -> IDLE, then a fresh run from BankAddr=0.
- Mid-run reset: assert rstSys at case 5, cyc 9 -> outputs 0 immediately, asynchronously; BankAddr=0 after release.
- SA_SEQ_CTRL_STALL_EN: stall=1 for 3 cycles at cyc 16 of case 2 -> start_check delayed 3 cycles, BankAddr=2 throughout, next case starts at BankAddr=3.

Source files
------------

// File: rtl/sa_seq_ctrl.sv
// Systolic-array test sequencer: walks BankAddr over every case, clears the PEs,
// strobes the operand feed and flags result-valid. Optional SA_SEQ_CTRL_STALL_EN adds a stall input.
module sa_seq_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int NUM_CASES   = 1024,
  parameter int K_LEN       = 8,
  parameter int CASE_CYCLES = 17,
  parameter int IDX_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rstSys,
  input  logic                  startSys,
`ifdef SA_SEQ_CTRL_STALL_EN
  input  logic                  stall,
`endif
  output logic [ADDR_WIDTH-1:0] BankAddr,
  output logic                  MemEn,
  output logic                  PeClear,
  output logic                  FeedValid,
  output logic [IDX_WIDTH-1:0]  FeedIdx,
  output logic                  start_check,
  output logic                  busy,
  output logic                  done
);

  localparam int CYC_W = (CASE_CYCLES > 2) ? $clog2(CASE_CYCLES) : 1;
  localparam logic [CYC_W-1:0]      LAST_CYC  = CYC_W'(CASE_CYCLES - 1);
  localparam logic [CYC_W-1:0]      FEED_LAST = CYC_W'(K_LEN);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_CASES - 1);

  generate
    if (CASE_CYCLES < K_LEN + 2) begin : gBadCaseCycles
      $error("sa_seq_ctrl: CASE_CYCLES must be >= K_LEN+2");
    end
    if (K_LEN - 1 >= (1 << IDX_WIDTH)) begin : gBadIdxWidth
      $error("sa_seq_ctrl: IDX_WIDTH cannot hold K_LEN-1");
    end
  endgenerate

`ifndef SA_SEQ_CTRL_STALL_EN
  logic stall;
  assign stall = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CYC_W-1:0] cyc;

  always_ff @(posedge clk or posedge rstSys) begin
    if (rstSys) begin
      state    <= IDLE;
      cyc      <= '0;
      BankAddr <= '0;
    end else begin
      case (state)
        IDLE: if (startSys) begin
          state    <= RUN;
          cyc      <= '0;
          BankAddr <= '0;
        end
        RUN: if (!stall) begin
          if (cyc == LAST_CYC) begin
            if (BankAddr == LAST_ADDR) state <= DONE;
            else begin
              BankAddr <= BankAddr + ADDR_WIDTH'(1);
              cyc      <= '0;
            end
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end
        DONE: if (!startSys) begin
          // re-arm only once start has been released
          state    <= IDLE;
          cyc      <= '0;
          BankAddr <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode; bank data lags the address by one cycle, so the feed runs cyc 1..K_LEN
  logic run, feedWin;
  assign run         = (state == RUN);
  assign feedWin     = run && (cyc >= CYC_W'(1)) && (cyc <= FEED_LAST);
  assign busy        = run;
  assign MemEn       = run;
  assign done        = (state == DONE);
  assign PeClear     = run && (cyc == '0) && !stall;
  assign FeedValid   = feedWin && !stall;
  assign FeedIdx     = feedWin ? IDX_WIDTH'(cyc - CYC_W'(1)) : '0;
  assign start_check = run && (cyc == LAST_CYC) && !stall;

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Scoreboard bench for sa_seq_ctrl: arithmetic reference model (case = elapsed/CC),
// start_check events queued at run start and popped by an independent monitor.
module tb_sa_seq_ctrl;
  localparam int AW = 10, NC = 1024, KL = 8, CC = 17, IW = 3;
  localparam int TOTAL = NC * CC;
`ifdef SA_SEQ_CTRL_STALL_EN
  localparam int STALL_SHIFT = 3;
`else
  localparam int STALL_SHIFT = 0;
`endif

  logic clk = 1'b0, rstSys = 1'b1, startSys = 1'b0, stall = 1'b0;
  logic [AW-1:0] BankAddr;
  logic [IW-1:0] FeedIdx;
  logic MemEn, PeClear, FeedValid, start_check, busy, done;

  always #5 clk = ~clk;

  sa_seq_ctrl #(.ADDR_WIDTH(AW), .NUM_CASES(NC), .K_LEN(KL), .CASE_CYCLES(CC), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rstSys(rstSys), .startSys(startSys),
`ifdef SA_SEQ_CTRL_STALL_EN
    .stall(stall),
`endif
    .BankAddr(BankAddr), .MemEn(MemEn), .PeClear(PeClear), .FeedValid(FeedValid),
    .FeedIdx(FeedIdx), .start_check(start_check), .busy(busy), .done(done)
  );

  int nVec = 0, nErr = 0;
  int cycN = 0, runStart = 0, stallDone = 0;
  bit mode = 1'b0;  // 0: idle expected, 1: run in progress (or finished, held in DONE)

  typedef struct { int addr; int cyc; } sc_t;
  sc_t scq[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    nVec++;
    if (got !== want) begin
      nErr++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", nm, got, want, cycN);
    end
  endtask

  // cycle counter plus count of stall cycles consumed inside the run
  always @(posedge clk) begin
    int e;
    e = cycN - runStart - stallDone;
    if (mode && stall && !rstSys && e >= 0 && e < TOTAL) stallDone++;
    cycN++;
  end

  // monitor: whole output word against the model, start_check against the scoreboard
  always @(negedge clk) begin
    int e, k, c;
    logic [18:0] expV, actV;
    logic [IW-1:0] fi;
    sc_t s;
    actV = {busy, MemEn, done, PeClear, FeedValid, start_check, FeedIdx, BankAddr};
    expV = '0;
    if (mode) begin
      e = cycN - runStart - stallDone;
      if (e < TOTAL) begin
        k  = e / CC;
        c  = e % CC;
        fi = (c >= 1 && c <= KL) ? IW'(c - 1) : '0;
        expV = {1'b1, 1'b1, 1'b0, (c == 0) && !stall, (c >= 1 && c <= KL) && !stall,
                (c == CC - 1) && !stall, fi, AW'(k)};
      end else begin
        expV = {1'b0, 1'b0, 1'b1, 3'b000, {IW{1'b0}}, AW'(NC - 1)};
      end
    end
    chk("outs", 32'(actV), 32'(expV));
    if (start_check) begin
      if (scq.size() == 0) chk("sc_unexpected", 32'(scq.size()), 32'd1);
      else begin
        s = scq.pop_front();
        chk("sc_addr", 32'(BankAddr), 32'(s.addr));
        chk("sc_cycle", 32'(cycN), 32'(s.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic startRun(input int shift);
    startSys = 1'b1;
    tick();
    stallDone = 0;
    runStart  = cycN;
    mode      = 1'b1;
    for (int k = 0; k < NC; k++)
      scq.push_back('{k, runStart + k * CC + CC - 1 + ((k >= 2) ? shift : 0)});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rstSys = 1'b0;
    repeat (20) tick();

    // run 1: full run with start held, stall at case 2 / cyc 16 when enabled
    repeat ($urandom_range(1, 6)) tick();
    startRun(STALL_SHIFT);
`ifdef SA_SEQ_CTRL_STALL_EN
    while (cycN - runStart != 2 * CC + CC - 1) tick();
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
`endif
    while (cycN - runStart < TOTAL + STALL_SHIFT + 10 + int'($urandom_range(0, 10))) tick();
    chk("sc_left_run1", 32'(scq.size()), 32'd0);

    // re-arm: one cycle of start low, then a fresh run aborted by reset at case 5 cyc 9
    startSys = 1'b0;
    tick();
    mode = 1'b0;
    startRun(0);
    while (cycN - runStart != 5 * CC + 9) tick();
    rstSys = 1'b1;
    startSys = 1'b0;
    #1;
    chk("rst_async", 32'({busy, MemEn, done, PeClear, FeedValid, start_check, FeedIdx, BankAddr}), 32'd0);
    mode = 1'b0;
    scq.delete();
    repeat (2) tick();
    rstSys = 1'b0;
    repeat ($urandom_range(3, 12)) tick();

    // run 3: full run after abort, starts again from case 0
    startRun(0);
    while (cycN - runStart < TOTAL + 5 + int'($urandom_range(0, 20))) tick();
    chk("sc_left_run3", 32'(scq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
